// File: rtl/countdown_timer_bcd.sv
// M:SS BCD countdown timer with load/start/stop/clear and a one-cycle done pulse.
// Prescaler divides clk down to one-second steps of CLK_DIV cycles.
module countdown_timer_bcd #(
   parameter int CLK_DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] load_mins,
   input  logic [3:0] load_sec_tens,
   input  logic [3:0] load_sec_ones,
   input  logic       start,
   input  logic       stop,
   input  logic       clear_time,
   output logic [3:0] mins,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       done
);

   localparam int             PW     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0]  PS_MAX = PW'(CLK_DIV - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RUNNING = 2'd1;
   localparam logic [1:0] S_PAUSED  = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0]    r_state;
   logic [PW-1:0] r_presc;
   logic [3:0]    r_mins, r_tens, r_ones;
   logic          r_running, r_done;

   logic [1:0]    w_state_nx;
   logic [PW-1:0] w_presc_nx;
   logic [3:0]    w_mins_nx, w_tens_nx, w_ones_nx;
   logic [3:0]    w_dec_mins, w_dec_tens, w_dec_ones;
   logic [3:0]    w_clp_mins, w_clp_tens, w_clp_ones;
   logic          w_zero, w_last, w_tick, w_can_load;

   assign w_zero     = (r_mins == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd0);
   assign w_last     = (r_mins == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd1);
   assign w_tick     = (r_presc == PS_MAX);
   assign w_can_load = (r_state == S_IDLE) || (r_state == S_PAUSED);

   assign w_clp_mins = (load_mins     > 4'd9) ? 4'd9 : load_mins;
   assign w_clp_tens = (load_sec_tens > 4'd5) ? 4'd5 : load_sec_tens;
   assign w_clp_ones = (load_sec_ones > 4'd9) ? 4'd9 : load_sec_ones;

   // One-second BCD decrement with borrow chain ones -> tens -> mins.
   always_comb begin
      w_dec_mins = r_mins;
      w_dec_tens = r_tens;
      w_dec_ones = r_ones;
      if (r_ones != 4'd0) begin
         w_dec_ones = r_ones - 4'd1;
      end else begin
         w_dec_ones = 4'd9;
         if (r_tens != 4'd0) begin
            w_dec_tens = r_tens - 4'd1;
         end else begin
            w_dec_tens = 4'd5;
            w_dec_mins = (r_mins != 4'd0) ? r_mins - 4'd1 : 4'd0;
         end
      end
   end

   // Priority: clear_time > load > stop > start; ignored commands fall through.
   always_comb begin
      w_state_nx = r_state;
      w_presc_nx = r_presc;
      w_mins_nx  = r_mins;
      w_tens_nx  = r_tens;
      w_ones_nx  = r_ones;
      if (clear_time) begin
         w_state_nx = S_IDLE;
         w_presc_nx = '0;
         w_mins_nx  = 4'd0;
         w_tens_nx  = 4'd0;
         w_ones_nx  = 4'd0;
      end else if (load && w_can_load) begin
         w_state_nx = S_IDLE;
         w_presc_nx = '0;
         w_mins_nx  = w_clp_mins;
         w_tens_nx  = w_clp_tens;
         w_ones_nx  = w_clp_ones;
      end else if (stop && (r_state == S_RUNNING)) begin
         w_state_nx = S_PAUSED;
      end else if (start && (r_state == S_IDLE)) begin
         if (!w_zero) begin
            w_state_nx = S_RUNNING;
            w_presc_nx = '0;
         end
      end else if (start && (r_state == S_PAUSED)) begin
         w_state_nx = S_RUNNING;
      end else begin
         case (r_state)
            S_RUNNING: begin
               if (w_tick) begin
                  w_presc_nx = '0;
                  w_mins_nx  = w_dec_mins;
                  w_tens_nx  = w_dec_tens;
                  w_ones_nx  = w_dec_ones;
                  if (w_last) w_state_nx = S_DONE;
               end else begin
                  w_presc_nx = r_presc + 1'b1;
               end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_presc   <= '0;
         r_mins    <= 4'd0;
         r_tens    <= 4'd0;
         r_ones    <= 4'd0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_presc   <= w_presc_nx;
         r_mins    <= w_mins_nx;
         r_tens    <= w_tens_nx;
         r_ones    <= w_ones_nx;
         r_running <= (w_state_nx == S_RUNNING);
         r_done    <= (w_state_nx == S_DONE);
      end
   end

   assign mins     = r_mins;
   assign sec_tens = r_tens;
   assign sec_ones = r_ones;
   assign running  = r_running;
   assign done     = r_done;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Table-driven bench for countdown_timer_bcd (CLK_DIV=4) with an expected-value queue.
module tb_countdown_timer_bcd;

   typedef struct {
      string      name;
      logic       ld;
      logic [3:0] lm, lt, lo;
      logic       clr, st, sp;
      logic [3:0] em, et, eo;
      logic       er, ed;
   } rec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load = 1'b0, start = 1'b0, stop = 1'b0, clear_time = 1'b0;
   logic [3:0] load_mins = 4'd0, load_sec_tens = 4'd0, load_sec_ones = 4'd0;
   logic [3:0] mins, sec_tens, sec_ones;
   logic       running, done;

   int n_chk = 0;
   int n_pass = 0;

   logic [13:0] exp_q[$];
   string       nm_q[$];
   rec_t        tbl[$];

   countdown_timer_bcd #(.CLK_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .load(load),
      .load_mins(load_mins), .load_sec_tens(load_sec_tens), .load_sec_ones(load_sec_ones),
      .start(start), .stop(stop), .clear_time(clear_time),
      .mins(mins), .sec_tens(sec_tens), .sec_ones(sec_ones),
      .running(running), .done(done)
   );

   always #5 clk = ~clk;

   function automatic rec_t mk(input string n, input logic ld, input logic [3:0] lm, lt, lo,
                               input logic clr, st, sp, input logic [3:0] em, et, eo,
                               input logic er, ed);
      rec_t r;
      r.name = n; r.ld = ld; r.lm = lm; r.lt = lt; r.lo = lo;
      r.clr = clr; r.st = st; r.sp = sp;
      r.em = em; r.et = et; r.eo = eo; r.er = er; r.ed = ed;
      return r;
   endfunction

   task automatic check(input string n, input logic [13:0] exp);
      logic [13:0] act;
      act = {mins, sec_tens, sec_ones, running, done};
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h:%0h%0h run=%0b done=%0b, expected %0h:%0h%0h run=%0b done=%0b",
                    n, act[13:10], act[9:6], act[5:2], act[1], act[0],
                    exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
   endtask

   // Drive one cycle of inputs, queue its expectation, compare after the edge.
   task automatic step(input rec_t r);
      @(negedge clk);
      load = r.ld; load_mins = r.lm; load_sec_tens = r.lt; load_sec_ones = r.lo;
      clear_time = r.clr; start = r.st; stop = r.sp;
      exp_q.push_back({r.em, r.et, r.eo, r.er, r.ed});
      nm_q.push_back(r.name);
      @(posedge clk);
      #1;
      check(nm_q.pop_front(), exp_q.pop_front());
   endtask

   task automatic idle(input string n, input logic [3:0] m, t, o, input logic r, d);
      step(mk(n, 0, 0, 0, 0, 0, 0, 0, m, t, o, r, d));
   endtask

   initial begin
      // name, ld, lm, lt, lo, clr, st, sp, em, et, eo, run, done
      tbl.push_back(mk("load_012",  1, 0, 1, 2, 0, 0, 0, 0, 1, 2, 0, 0));
      tbl.push_back(mk("start_012", 0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 1, 0));
      tbl.push_back(mk("p1",        0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0));
      tbl.push_back(mk("p2",        0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0));
      tbl.push_back(mk("p3",        0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0));
      tbl.push_back(mk("edge4_011", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
      tbl.push_back(mk("p1b",       0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
      tbl.push_back(mk("p2b",       0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
      tbl.push_back(mk("p3b",       0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
      tbl.push_back(mk("edge8_010", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
      tbl.push_back(mk("load_run_ign", 1, 5, 5, 5, 0, 0, 0, 0, 1, 0, 1, 0));
      tbl.push_back(mk("p2c",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
      tbl.push_back(mk("p3c",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
      tbl.push_back(mk("edge12_009", 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 1, 0));
      tbl.push_back(mk("clr_and_load", 1, 7, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk("load_100",  1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk("start_100", 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0));
      tbl.push_back(mk("b1",        0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
      tbl.push_back(mk("b2",        0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
      tbl.push_back(mk("b3",        0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
      tbl.push_back(mk("borrow_059", 0, 0, 0, 0, 0, 0, 0, 0, 5, 9, 1, 0));
      tbl.push_back(mk("clr_run",   0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk("load_001",  1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk("start_001", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk("t1",        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk("t2",        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk("t3",        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk("done_pulse", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk("done_drop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk("start_zero_ign", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk("still_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk("clamp_959", 1, 4'hF, 4'h7, 4'hB, 0, 0, 0, 9, 5, 9, 0, 0));
      tbl.push_back(mk("load_001b", 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk("start_001b", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk("s1",        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk("s2",        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk("s3",        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk("stop_on_tick", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(mk("paused_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk("resume_tick", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk("resume_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk("resume_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      #1;
      check("reset_async", 14'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("reset_state", 14'd0);

      foreach (tbl[i]) step(tbl[i]);

      // Pause at prescaler=2, hold ten cycles, resume two edges from decrement.
      step(mk("pr_load",  1, 0, 0, 5, 0, 0, 0, 0, 0, 5, 0, 0));
      step(mk("pr_start", 0, 0, 0, 0, 0, 1, 0, 0, 0, 5, 1, 0));
      idle("pr_p1", 0, 0, 5, 1, 0);
      idle("pr_p2", 0, 0, 5, 1, 0);
      step(mk("pr_stop",  0, 0, 0, 0, 0, 0, 1, 0, 0, 5, 0, 0));
      for (int k = 0; k < 10; k++) idle("pr_frozen", 0, 0, 5, 0, 0);
      step(mk("pr_resume", 0, 0, 0, 0, 0, 1, 0, 0, 0, 5, 1, 0));
      idle("pr_r1", 0, 0, 5, 1, 0);
      idle("pr_r2_dec", 0, 0, 4, 1, 0);

      // Load while paused returns to IDLE with the new preset.
      step(mk("pl_stop",  0, 0, 0, 0, 0, 0, 1, 0, 0, 4, 0, 0));
      step(mk("pl_load",  1, 2, 3, 4, 0, 0, 0, 2, 3, 4, 0, 0));
      step(mk("pl_start_ign_stop", 0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 0, 0));

      // Asynchronous reset between edges.
      step(mk("ar_start", 0, 0, 0, 0, 0, 1, 0, 2, 3, 4, 1, 0));
      idle("ar_p1", 2, 3, 4, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_async_clear", 14'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(mk("ar_start_zero_ign", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      idle("ar_idle", 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
